// File: rtl/regfile_mp_init.sv
`timescale 1ns/1ps
`default_nettype none
//-----------------------------------------------------------------------------
// Module  : regfile_mp_init
// Brief   : Multi-port register file, two prioritised write ports, sequential
//           clear sweep after reset/request. Bypass option: REGFILE_BYPASS_EN.
// Revision: 1.0
//-----------------------------------------------------------------------------
module regfile_mp_init #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NREG    = 32,
   parameter int unsigned AW      = 5,
   parameter int unsigned NRD     = 2,
   parameter bit          ZERO_R0 = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear_req,
   output logic                busy,
   input  logic                we_a,
   input  logic [AW-1:0]       wa_a,
   input  logic [XLEN-1:0]     wd_a,
   input  logic                we_b,
   input  logic [AW-1:0]       wa_b,
   input  logic [XLEN-1:0]     wd_b,
   input  logic [NRD*AW-1:0]   ra,
   output logic [NRD*XLEN-1:0] rd
);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam logic [AW-1:0] LAST_PTR = AW'(NREG - 1);

   state_t          state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [XLEN-1:0] mem_q [NREG];
   logic [XLEN-1:0] mem_d [NREG];

   logic            wr_a_ok;
   logic            wr_b_ok;

   assign busy = (state_q == ST_CLEAR);

   // Writes to a hard-wired zero register are dropped at the source.
   assign wr_a_ok = !busy && we_a && !(ZERO_R0 && (wa_a == '0));
   assign wr_b_ok = !busy && we_b && !(ZERO_R0 && (wa_b == '0));

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_CLEAR: begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == LAST_PTR) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            if (clear_req) begin
               state_d = ST_CLEAR;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Port B is applied after port A so it wins an address collision.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (rst_n) begin
         if (busy) begin
            mem_d[ptr_q] = '0;
         end else begin
            if (wr_a_ok) begin
               mem_d[wa_a] = wd_a;
            end
            if (wr_b_ok) begin
               mem_d[wa_b] = wd_b;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0]   rd_addr;
      logic [XLEN-1:0] rd_data;

      assign rd_addr = ra[p*AW +: AW];

      always_comb begin
         rd_data = mem_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
         if (we_a && (wa_a == rd_addr)) begin
            rd_data = wd_a;
         end
         if (we_b && (wa_b == rd_addr)) begin
            rd_data = wd_b;
         end
`endif
         if (busy || (ZERO_R0 && (rd_addr == '0))) begin
            rd_data = '0;
         end
      end

      assign rd[p*XLEN +: XLEN] = rd_data;
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_init.sv
`timescale 1ns/1ps
`default_nettype none
// Randomised bench for regfile_mp_init: default build and a 64x16, 3-read,
// ordinary-r0 build, both checked against an array-level model.
module tb_regfile_mp_init;

   logic clk = 1'b0;
   logic rst_n;
   logic clear_req;

   logic         we_a0, we_b0, busy0;
   logic [4:0]   wa_a0, wa_b0;
   logic [31:0]  wd_a0, wd_b0;
   logic [9:0]   ra0;
   logic [63:0]  rd0;

   logic         we_a1, we_b1, busy1;
   logic [3:0]   wa_a1, wa_b1;
   logic [63:0]  wd_a1, wd_b1;
   logic [11:0]  ra1;
   logic [191:0] rd1;

   always #5 clk = ~clk;

   regfile_mp_init u_dut0 (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy0),
      .we_a(we_a0), .wa_a(wa_a0), .wd_a(wd_a0),
      .we_b(we_b0), .wa_b(wa_b0), .wd_b(wd_b0),
      .ra(ra0), .rd(rd0)
   );

   regfile_mp_init #(
      .XLEN(64), .NREG(16), .AW(4), .NRD(3), .ZERO_R0(1'b0)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy1),
      .we_a(we_a1), .wa_a(wa_a1), .wd_a(wd_a1),
      .we_b(we_b1), .wa_b(wa_b1), .wd_b(wd_b1),
      .ra(ra1), .rd(rd1)
   );

   // Reference model: array contents plus cycles of sweep still to run.
   // Entries are unobservable during a sweep, so the array is zeroed as a
   // whole when the sweep completes.
   logic [31:0] m0 [32];
   logic [63:0] m1 [16];
   int          left0, left1;
   bit          valid = 1'b0;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp0(input logic [4:0] a);
      if (left0 > 0) return '0;
      if (a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (we_b0 && wa_b0 == a) return wd_b0;
      if (we_a0 && wa_a0 == a) return wd_a0;
`endif
      return m0[a];
   endfunction

   function automatic logic [63:0] exp1(input logic [3:0] a);
      if (left1 > 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (we_b1 && wa_b1 == a) return wd_b1;
      if (we_a1 && wa_a1 == a) return wd_a1;
`endif
      return m1[a];
   endfunction

   task automatic model_update();
      if (!rst_n) begin
         left0 = 32;
         left1 = 16;
         valid = 1'b1;
      end else if (valid) begin
         if (left0 > 0) begin
            left0--;
            if (left0 == 0) for (int i = 0; i < 32; i++) m0[i] = '0;
         end else begin
            if (we_a0 && wa_a0 != 5'd0) m0[wa_a0] = wd_a0;
            if (we_b0 && wa_b0 != 5'd0) m0[wa_b0] = wd_b0;
            if (clear_req) left0 = 32;
         end
         if (left1 > 0) begin
            left1--;
            if (left1 == 0) for (int i = 0; i < 16; i++) m1[i] = '0;
         end else begin
            if (we_a1) m1[wa_a1] = wd_a1;
            if (we_b1) m1[wa_b1] = wd_b1;
            if (clear_req) left1 = 16;
         end
      end
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic tick();
      #1;
      if (valid) begin
         check("busy0", {63'd0, busy0}, {63'd0, left0 > 0});
         check("busy1", {63'd0, busy1}, {63'd0, left1 > 0});
         for (int p = 0; p < 2; p++)
            check($sformatf("dut0_rd%0d", p), {32'd0, rd0[p*32 +: 32]}, {32'd0, exp0(ra0[p*5 +: 5])});
         for (int p = 0; p < 3; p++)
            check($sformatf("dut1_rd%0d", p), rd1[p*64 +: 64], exp1(ra1[p*4 +: 4]));
      end
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      we_a0 = 1'b0; we_b0 = 1'b0; we_a1 = 1'b0; we_b1 = 1'b0;
      clear_req = 1'b0;
      ra0 = 10'($urandom);
      ra1 = 12'($urandom);
   endtask

   int b0, b1, n;

   initial begin
      rst_n = 1'b0;
      idle();
      wa_a0 = '0; wa_b0 = '0; wd_a0 = '0; wd_b0 = '0;
      wa_a1 = '0; wa_b1 = '0; wd_a1 = '0; wd_b1 = '0;
      @(negedge clk);

      // Reset and initial sweep, with writes attempted while busy
      tick();
      tick();
      rst_n = 1'b1;
      b0 = 0; b1 = 0;
      for (int i = 0; i < 40; i++) begin
         we_a0 = busy0; wa_a0 = 5'd5; wd_a0 = $urandom;
         we_a1 = busy1; wa_a1 = 4'd5; wd_a1 = {$urandom, $urandom};
         b0 += int'(busy0);
         b1 += int'(busy1);
         tick();
      end
      check("sweep_len0", 64'(b0), 64'd32);
      check("sweep_len1", 64'(b1), 64'd16);
      idle();
      ra0 = {5'd5, 5'd5};
      ra1 = {4'd5, 4'd5, 4'd5};
      #1 check("reg5_dropped0", {32'd0, rd0[31:0]}, 64'd0);
      check("reg5_dropped1", rd1[63:0], 64'd0);
      tick();

      // Basic write then dual-port read
      we_a0 = 1'b1; wa_a0 = 5'd3; wd_a0 = 32'hDEADBEEF;
      tick();
      idle();
      ra0 = {5'd3, 5'd3};
      #1 check("basic_p0", {32'd0, rd0[31:0]}, 64'hDEADBEEF);
      check("basic_p1", {32'd0, rd0[63:32]}, 64'hDEADBEEF);
      tick();

      // Collisions: port B wins; r0 writes vanish
      we_a0 = 1'b1; wa_a0 = 5'd7; wd_a0 = 32'h11;
      we_b0 = 1'b1; wa_b0 = 5'd7; wd_b0 = 32'h22;
      tick();
      we_a0 = 1'b1; wa_a0 = 5'd0; wd_a0 = 32'h33;
      we_b0 = 1'b1; wa_b0 = 5'd0; wd_b0 = 32'h44;
      tick();
      idle();
      ra0 = {5'd0, 5'd7};
      #1 check("collide_r7", {32'd0, rd0[31:0]}, 64'h22);
      check("collide_r0", {32'd0, rd0[63:32]}, 64'h0);
      tick();
      we_b0 = 1'b1; wa_b0 = 5'd0; wd_b0 = 32'h55;
      we_a0 = 1'b1; wa_a0 = 5'd12; wd_a0 = 32'h66;
      tick();
      idle();
      ra0 = {5'd0, 5'd12};
      #1 check("r0_no_block", {32'd0, rd0[31:0]}, 64'h66);
      tick();

      // Fill 1..31 with their index, then request a clear
      for (int r = 1; r < 32; r += 2) begin
         idle();
         we_a0 = 1'b1; wa_a0 = 5'(r); wd_a0 = 32'(r);
         we_b0 = (r + 1 < 32); wa_b0 = 5'(r + 1); wd_b0 = 32'(r + 1);
         tick();
      end
      idle();
      ra0 = {5'd31, 5'd17};
      #1 check("fill_r17", {32'd0, rd0[31:0]}, 64'd17);
      check("fill_r31", {32'd0, rd0[63:32]}, 64'd31);
      tick();
      clear_req = 1'b1;
      tick();
      n = 0;
      while (busy0 && n < 100) begin
         idle();
         clear_req = (n == 5);
         we_a0 = 1'b1; wa_a0 = 5'($urandom); wd_a0 = $urandom;
         n++;
         tick();
      end
      check("clear_len", 64'(n), 64'd32);
      for (int r = 0; r < 32; r += 2) begin
         idle();
         ra0 = {5'(r + 1), 5'(r)};
         #1 check("cleared", {32'd0, rd0[31:0] | rd0[63:32]}, 64'd0);
         tick();
      end

      // Reset in the middle of a requested sweep
      clear_req = 1'b1;
      tick();
      idle();
      repeat (10) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n = 0;
      while (busy0 && n < 100) begin
         idle();
         n++;
         tick();
      end
      check("restart_len", 64'(n), 64'd32);

      // Same-cycle bypass behaviour
      idle();
      we_b0 = 1'b1; wa_b0 = 5'd9; wd_b0 = 32'h1;
      tick();
      idle();
      we_b0 = 1'b1; wa_b0 = 5'd9; wd_b0 = 32'hABCD;
      ra0 = {5'd9, 5'd9};
`ifdef REGFILE_BYPASS_EN
      #1 check("bypass_now", {32'd0, rd0[31:0]}, 64'hABCD);
`else
      #1 check("bypass_now", {32'd0, rd0[31:0]}, 64'h1);
`endif
      tick();
      idle();
      ra0 = {5'd9, 5'd9};
      #1 check("bypass_next", {32'd0, rd0[63:32]}, 64'hABCD);
      tick();

      // Wide build: r0 is ordinary
      we_a1 = 1'b1; wa_a1 = 4'd0; wd_a1 = 64'h5A5A5A5A5A5A5A5A;
      tick();
      idle();
      ra1 = 12'd0;
      #1 for (int p = 0; p < 3; p++)
         check($sformatf("wide_r0_p%0d", p), rd1[p*64 +: 64], 64'h5A5A5A5A5A5A5A5A);
      tick();

      // Random traffic with occasional clear requests and resets
      for (int i = 0; i < 3000; i++) begin
         rst_n     = ($urandom_range(0, 299) != 0);
         clear_req = ($urandom_range(0, 79) == 0);
         we_a0 = 1'($urandom); we_b0 = 1'($urandom);
         wa_a0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         wa_b0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         wd_a0 = $urandom; wd_b0 = $urandom;
         we_a1 = 1'($urandom); we_b1 = 1'($urandom);
         wa_a1 = 4'($urandom); wa_b1 = 4'($urandom);
         wd_a1 = {$urandom, $urandom}; wd_b1 = {$urandom, $urandom};
         ra0 = 10'($urandom);
         ra1 = 12'($urandom);
         if ($urandom_range(0, 2) == 0) ra0[4:0] = wa_b0;
         if ($urandom_range(0, 2) == 0) ra0[9:5] = wa_a0;
         if ($urandom_range(0, 2) == 0) ra1[3:0] = wa_b1;
         if ($urandom_range(0, 2) == 0) ra1[7:4] = wa_a1;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
